// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction-fetch stage: PC register, ROM interface, IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic        i_branch_flag,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_rom_inst,
    output logic        o_rom_ce,
    output logic [31:0] o_rom_addr,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst,
    output logic        o_id_valid
);

    localparam logic [31:0] c_PC_STEP      = 32'd4;
    localparam logic [31:0] c_RESET_PC_AL  = {RESET_PC[31:2], 2'b00};

    // Per-edge action, decoded in priority order (rom_ce > stall > branch > seq).
    localparam logic [1:0] c_ACT_START    = 2'd0;
    localparam logic [1:0] c_ACT_HOLD     = 2'd1;
    localparam logic [1:0] c_ACT_REDIRECT = 2'd2;
    localparam logic [1:0] c_ACT_SEQ      = 2'd3;

    logic        r_rom_ce;
    logic [31:0] r_pc;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_inst;
    logic        r_id_valid;

    logic [1:0]  w_action;
    logic [31:0] w_pc_seq;
    logic [31:0] w_pc_target;
    logic        w_unused_tgt_lsb;

    assign w_pc_seq         = r_pc + c_PC_STEP;
    assign w_pc_target      = {i_branch_target[31:2], 2'b00};
    assign w_unused_tgt_lsb = ^i_branch_target[1:0];

    always_comb begin
        w_action = c_ACT_SEQ;
        if (!r_rom_ce) begin
            w_action = c_ACT_START;
        end else if (i_stall) begin
            w_action = c_ACT_HOLD;
        end else if (i_branch_flag) begin
            w_action = c_ACT_REDIRECT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rom_ce   <= 1'b0;
            r_pc       <= c_RESET_PC_AL;
            r_id_pc    <= 32'h0000_0000;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
        end else begin
            case (w_action)
                c_ACT_START: begin
                    r_rom_ce   <= 1'b1;
                    r_pc       <= c_RESET_PC_AL;
                    r_id_pc    <= 32'h0000_0000;
                    r_id_inst  <= NOP_INST;
                    r_id_valid <= 1'b0;
                end
                c_ACT_HOLD: begin
                    r_pc       <= r_pc;
                    r_id_pc    <= r_id_pc;
                    r_id_inst  <= r_id_inst;
                    r_id_valid <= r_id_valid;
                end
                c_ACT_REDIRECT: begin
                    // The word fetched this cycle belongs to the wrong path.
                    r_pc       <= w_pc_target;
                    r_id_pc    <= 32'h0000_0000;
                    r_id_inst  <= NOP_INST;
                    r_id_valid <= 1'b0;
                end
                default: begin
                    r_pc       <= w_pc_seq;
                    r_id_pc    <= r_pc;
                    r_id_inst  <= i_rom_inst;
                    r_id_valid <= 1'b1;
                end
            endcase
        end
    end

    assign o_rom_ce   = r_rom_ce;
    assign o_rom_addr = {r_pc[31:2], 2'b00};
    assign o_id_pc    = r_id_pc;
    assign o_id_inst  = r_id_inst;
    assign o_id_valid = r_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Self-checking bench for if_stage with a behavioural fetch model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic [31:0] rom_inst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_valid;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic        m_ce;
    logic [31:0] m_pc;
    logic [31:0] m_id_pc;
    logic [31:0] m_id_inst;
    logic        m_id_valid;

    always #5 clk = ~clk;

    if_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_stall        (stall),
        .i_branch_flag  (branch_flag),
        .i_branch_target(branch_target),
        .i_rom_inst     (rom_inst),
        .o_rom_ce       (rom_ce),
        .o_rom_addr     (rom_addr),
        .o_id_pc        (id_pc),
        .o_id_inst      (id_inst),
        .o_id_valid     (id_valid)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h11;
            32'h4: return 32'h22;
            32'h8: return 32'h33;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
        endcase
    endfunction

    assign rom_inst = rom_word(rom_addr);

    // Model: what the fetch stage should do on the coming edge, from the rules.
    task automatic model_edge;
        logic [31:0] fetched;
        fetched = rom_word(m_pc);
        if (!rst || !m_ce) begin
            m_ce = rst;
            m_pc = 32'h0;
            m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
        end else if (stall) begin
            // everything holds
        end else if (branch_flag) begin
            m_pc = branch_target & ~32'd3;
            m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
        end else begin
            m_id_pc = m_pc; m_id_inst = fetched; m_id_valid = 1'b1;
            m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic tick;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; stall = 1'b0; branch_flag = 1'b0; branch_target = 32'h0;
        tick(); tick();
        n_vec++;
        if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0}) begin
            n_err++;
            $display("FAIL reset: ce=%0b addr=%h id_pc=%h inst=%h v=%0b, required 0 0 0 %h 0",
                     rom_ce, rom_addr, id_pc, id_inst, id_valid, NOP);
        end
    endtask

    task automatic test_fetch_sequence;
        rst = 1'b1;
        tick();
        n_vec++;
        if (rom_ce !== 1'b1 || rom_addr !== 32'h0) begin
            n_err++;
            $display("FAIL edge1: ce=%0b addr=%h, required 1 00000000", rom_ce, rom_addr);
        end
        tick();
        n_vec++;
        if (id_pc !== 32'h0 || id_inst !== 32'h11 || id_valid !== 1'b1 || rom_addr !== 32'h4) begin
            n_err++;
            $display("FAIL edge2: id_pc=%h inst=%h v=%0b addr=%h, required 0 11 1 4",
                     id_pc, id_inst, id_valid, rom_addr);
        end
        tick();
        n_vec++;
        if (id_inst !== 32'h22 || rom_addr !== 32'h8) begin
            n_err++;
            $display("FAIL edge3: inst=%h addr=%h, required 22 8", id_inst, rom_addr);
        end
    endtask

    task automatic test_stall;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++;
            if (rom_addr !== 32'h8 || id_pc !== 32'h4) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: addr=%h id_pc=%h, required 8 4", i, rom_addr, id_pc);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if (id_pc !== 32'h8 || id_inst !== 32'h33 || rom_addr !== 32'hC) begin
            n_err++;
            $display("FAIL stall_release: id_pc=%h inst=%h addr=%h, required 8 33 c",
                     id_pc, id_inst, rom_addr);
        end
    endtask

    task automatic test_branch;
        logic [31:0] a_before;
        branch_flag = 1'b1; branch_target = 32'h103;
        tick();
        n_vec++;
        if (rom_addr !== 32'h100 || id_valid !== 1'b0 || id_inst !== NOP) begin
            n_err++;
            $display("FAIL branch_bubble: addr=%h v=%0b inst=%h, required 100 0 13",
                     rom_addr, id_valid, id_inst);
        end
        // Inputs changing mid-cycle must not reach rom_addr before the edge.
        a_before = rom_addr;
        branch_target = 32'hDEAD_BEEC; stall = 1'b1; #2;
        stall = 1'b0; branch_flag = 1'b0;
        n_vec++;
        if (rom_addr !== a_before) begin
            n_err++;
            $display("FAIL comb_path: addr=%h, required %h", rom_addr, a_before);
        end
        tick();
        n_vec++;
        if (id_pc !== 32'h100 || id_valid !== 1'b1 || id_inst !== rom_word(32'h100)) begin
            n_err++;
            $display("FAIL branch_target: id_pc=%h v=%0b inst=%h, required 100 1 %h",
                     id_pc, id_valid, id_inst, rom_word(32'h100));
        end
    endtask

    task automatic test_stall_branch;
        stall = 1'b1; branch_flag = 1'b1; branch_target = 32'h200;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_vec++;
            if (rom_addr !== 32'h104 || id_pc !== 32'h100) begin
                n_err++;
                $display("FAIL stall_branch_hold[%0d]: addr=%h id_pc=%h, required 104 100",
                         i, rom_addr, id_pc);
            end
        end
        stall = 1'b0;
        tick();
        n_vec++;
        if (rom_addr !== 32'h200 || id_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_branch_redirect: addr=%h v=%0b, required 200 0", rom_addr, id_valid);
        end
        branch_flag = 1'b0;
    endtask

    task automatic test_wrap;
        branch_flag = 1'b1; branch_target = 32'hFFFF_FFFF;
        tick();
        branch_flag = 1'b0;
        tick();
        n_vec++;
        if (rom_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC || id_valid !== 1'b1) begin
            n_err++;
            $display("FAIL wrap: addr=%h id_pc=%h v=%0b, required 0 fffffffc 1",
                     rom_addr, id_pc, id_valid);
        end
    endtask

    task automatic test_reset_during_branch;
        tick(); tick();
        branch_flag = 1'b1; branch_target = 32'h300; rst = 1'b0;
        tick();
        n_vec++;
        if ({rom_ce, rom_addr, id_pc, id_inst, id_valid} !== {1'b0, 32'h0, 32'h0, NOP, 1'b0}) begin
            n_err++;
            $display("FAIL reset_branch: ce=%0b addr=%h id_pc=%h inst=%h v=%0b, required 0 0 0 %h 0",
                     rom_ce, rom_addr, id_pc, id_inst, id_valid, NOP);
        end
        rst = 1'b1; branch_flag = 1'b0;
        tick(); tick();
        n_vec++;
        if (rom_addr !== 32'h4 || id_pc !== 32'h0 || id_inst !== 32'h11 || id_valid !== 1'b1) begin
            n_err++;
            $display("FAIL reset_branch_restart: addr=%h id_pc=%h inst=%h v=%0b, required 4 0 11 1",
                     rom_addr, id_pc, id_inst, id_valid);
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            // A redirect held under stall must persist until stall drops.
            if (!(stall && branch_flag && rst)) begin
                branch_flag   = ($urandom_range(0, 5) == 0);
                branch_target = $urandom();
                if ($urandom_range(0, 7) == 0) branch_target = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            end
            stall = ($urandom_range(0, 3) == 0);
            rst   = ($urandom_range(0, 60) != 0);
            tick();
            n_vec++;
            if (rom_ce !== m_ce || rom_addr !== m_pc || id_pc !== m_id_pc ||
                id_inst !== m_id_inst || id_valid !== m_id_valid || rom_addr[1:0] !== 2'b00) begin
                n_err++;
                $display("FAIL random[%0d]: ce=%0b addr=%h id_pc=%h inst=%h v=%0b, required %0b %h %h %h %0b",
                         i, rom_ce, rom_addr, id_pc, id_inst, id_valid,
                         m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid);
            end
        end
    endtask

    initial begin
        m_ce = 1'b0; m_pc = 32'h0; m_id_pc = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
        test_reset();
        test_fetch_sequence();
        test_stall();
        test_branch();
        test_stall_branch();
        test_wrap();
        test_reset_during_branch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
